// File: rtl/uart_fifo.sv
// Buffered full-duplex UART: TX and RX bit engines with a FIFO per direction.
// TX side takes characters through a valid/ready push port; RX side is a
// first-word-fall-through FIFO with valid/ready pop.
// Optional feature macro: UART_PARITY_EN (adds a parity bit, odd when PARITY_ODD=1).
module uart_fifo #(
  parameter int unsigned CLOCK_HZ   = 12_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         rx_pin,
  output logic                         tx_pin,
  input  logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  tx_count,
  output logic [$clog2(FIFO_DEPTH):0]  rx_count,
  output logic                         overrun,
  output logic                         frame_error,
  output logic                         parity_error
);

  localparam int unsigned DIV = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DivLast  = CW'(DIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(DIV / 2 - 1);
  localparam logic [2:0]    BitLast  = 3'(DATA_BITS - 1);

  if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 || PARITY_ODD > 1)
  begin : g_bad_params
    $error("uart_fifo: illegal parameter combination");
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wr_q, tx_rd_q;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_count = tx_wr_q - tx_rd_q;
  assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];

  // TX FIFO storage write
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= tx_data;
  end

  // TX FIFO pointers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX engine
  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_e;

  tx_state_e            tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_pin_q;
  logic                 tx_line;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  // Fetch a new character from idle, or straight out of a finished stop bit
  assign tx_pop = !tx_empty &&
                  ((tx_state_q == TxIdle) || (tx_state_q == TxStop && tx_cnt_q == DivLast));

  // Line level implied by the current state; registered into tx_pin_q
  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state_q)
      TxStart:  tx_line = 1'b0;
      TxData:   tx_line = tx_shift_q[0];
`ifdef UART_PARITY_EN
      TxParity: tx_line = tx_par_q;
`endif
      default:  tx_line = 1'b1;
    endcase
  end

  // TX state machine; each state lasts DIV cycles
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_pin_q   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_pin_q <= tx_line;
      if (tx_pop) begin
        tx_shift_q <= tx_head;
`ifdef UART_PARITY_EN
        tx_par_q   <= (^tx_head) ^ (PARITY_ODD != 0);
`endif
      end
      unique case (tx_state_q)
        TxIdle: begin
          tx_cnt_q <= '0;
          if (tx_pop) tx_state_q <= TxStart;
        end
        TxStart: begin
          if (tx_cnt_q == DivLast) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TxData;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TxData: begin
          if (tx_cnt_q == DivLast) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= tx_shift_q >> 1;
            if (tx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
              tx_state_q <= TxParity;
`else
              tx_state_q <= TxStop;
`endif
            end else tx_bit_q <= tx_bit_q + 1'b1;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
`ifdef UART_PARITY_EN
        TxParity: begin
          if (tx_cnt_q == DivLast) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TxStop;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
`endif
        TxStop: begin
          if (tx_cnt_q == DivLast) begin
            tx_cnt_q   <= '0;
            tx_state_q <= tx_pop ? TxStart : TxIdle;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign tx_pin = tx_pin_q;

  // ---------------------------------------------------------------- RX engine
  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop,
    RxWaitHigh
  } rx_state_e;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e            rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_done_q, rx_stop_ok_q, rx_good;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad_q;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_pin;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX state machine; rx_done_q flags a completed stop-bit sample for one cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_done_q    <= 1'b0;
      rx_stop_ok_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_done_q <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_state_q <= RxStart;
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            // A line already high again at mid-start is a glitch
            rx_state_q <= rx_s2_q ? RxIdle : RxData;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RxData: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
              rx_state_q <= RxParity;
`else
              rx_state_q <= RxStop;
`endif
            end else rx_bit_q <= rx_bit_q + 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
`ifdef UART_PARITY_EN
        RxParity: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q     <= '0;
            rx_par_bad_q <= rx_s2_q != ((^rx_shift_q) ^ (PARITY_ODD != 0));
            rx_state_q   <= RxStop;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
`endif
        RxStop: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q     <= '0;
            rx_done_q    <= 1'b1;
            rx_stop_ok_q <= rx_s2_q;
            rx_state_q   <= rx_s2_q ? RxIdle : RxWaitHigh;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RxWaitHigh: begin
          if (rx_s2_q) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  assign rx_good = rx_done_q && rx_stop_ok_q && !rx_par_bad_q;
`else
  assign rx_good = rx_done_q && rx_stop_ok_q;
`endif

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wr_q, rx_rd_q;
  logic                 rx_full, rx_empty, rx_push, rx_pop;
  logic                 overrun_q, frame_error_q, parity_error_q;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  // A same-cycle pop frees the slot the push is about to fill
  assign rx_push  = rx_good && (!rx_full || rx_pop);
  assign rx_count = rx_wr_q - rx_rd_q;
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd_q[AW-1:0]];

  // RX FIFO storage write
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end

  // RX FIFO pointers and error pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      overrun_q      <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      overrun_q     <= rx_good && rx_full && !rx_pop;
      frame_error_q <= rx_done_q && !rx_stop_ok_q;
`ifdef UART_PARITY_EN
      parity_error_q <= rx_done_q && rx_stop_ok_q && rx_par_bad_q;
`else
      parity_error_q <= 1'b0;
`endif
    end
  end

  assign overrun      = overrun_q;
  assign frame_error  = frame_error_q;
  assign parity_error = parity_error_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo at DIV=10, 8 data bits, 4-deep FIFOs.
module tb_uart_fifo;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_drive = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_pin_w;
  logic       tx_pin;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] tx_count, rx_count;
  logic       overrun, frame_error, parity_error;

  int n_checks = 0;
  int n_bad = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0;

  assign rx_pin_w = loop_en ? tx_pin : rx_drive;

  always #5 clock = ~clock;

  uart_fifo #(
    .CLOCK_HZ  (1_000_000),
    .BAUD_RATE (100_000),
    .DATA_BITS (8),
    .FIFO_DEPTH(4),
    .PARITY_ODD(0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_pin      (rx_pin_w),
    .tx_pin      (tx_pin),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .overrun     (overrun),
    .frame_error (frame_error),
    .parity_error(parity_error)
  );

  // Pulse counters, sampled mid-cycle
  always @(negedge clock) begin
    if (reset_n) begin
      if (frame_error)  n_fe++;
      if (parity_error) n_pe++;
      if (overrun)      n_ov++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Push one character into an idle TX side and check every line cycle
  task automatic tx_frame_check(input logic [7:0] d, input logic p);
    logic [10:0] fr;
    int nb;
`ifdef UART_PARITY_EN
    nb = 11;
    fr = {1'b1, p, d, 1'b0};
`else
    nb = 10;
    fr = {1'b0, 1'b1, d, 1'b0};
`endif
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check_eq("tx_count_after_push", 32'(tx_count), 32'd1);
    tick();
    check_eq("tx_pin_before_start", 32'(tx_pin), 32'd1);
    for (int k = 0; k < nb * 10; k++) begin
      tick();
      check_eq($sformatf("tx_line_bit%0d", k / 10), 32'(tx_pin), 32'(fr[k / 10]));
    end
    tick();
    check_eq("tx_pin_idle_after", 32'(tx_pin), 32'd1);
    check_eq("tx_count_after_frame", 32'(tx_count), 32'd0);
  endtask

  // Drive one frame onto rx_pin, then a short idle gap
  task automatic send_rx(input logic [7:0] d, input logic p, input logic stop);
    logic [10:0] fr;
    int nb;
`ifdef UART_PARITY_EN
    nb = 11;
    fr = {stop, p, d, 1'b0};
`else
    nb = 10;
    fr = {1'b0, stop, d, 1'b0};
`endif
    for (int k = 0; k < nb; k++) begin
      rx_drive = fr[k];
      repeat (10) @(posedge clock);
      #1;
    end
    rx_drive = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] got [8];
    logic [7:0] lb_vec [4];
    int n_got, fe0, pe0, ov0;

    // Reset
    repeat (3) tick();
    check_eq("rst_tx_pin", 32'(tx_pin), 32'd1);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_tx_count", 32'(tx_count), 32'd0);
    check_eq("rst_rx_count", 32'(rx_count), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_frame_error", 32'(frame_error), 32'd0);
    check_eq("rst_parity_error", 32'(parity_error), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // TX frame; 0xA5 has even parity bit 0
    tx_frame_check(8'hA5, 1'b0);
`ifdef UART_PARITY_EN
    tx_frame_check(8'h07, 1'b1);
`endif

    // Reset in the middle of a start bit with a second character queued
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_data = 8'h66;
    tick();
    tx_valid = 1'b0;
    repeat (4) tick();
    check_eq("midrst_pin_low", 32'(tx_pin), 32'd0);
    check_eq("midrst_count_pre", 32'(tx_count), 32'd1);
    reset_n = 1'b0;
    tick();
    check_eq("midrst_pin_high", 32'(tx_pin), 32'd1);
    check_eq("midrst_count_zero", 32'(tx_count), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check_eq("midrst_pin_stays_high", 32'(tx_pin), 32'd1);

    // Loopback burst
    lb_vec[0] = 8'h00; lb_vec[1] = 8'hFF; lb_vec[2] = 8'h3C; lb_vec[3] = 8'h81;
    loop_en  = 1'b1;
    rx_ready = 1'b1;
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    n_got = 0;
    for (int i = 0; i < 4; i++) begin
      tx_data  = lb_vec[i];
      tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (rx_valid && n_got < 8) begin
        got[n_got] = rx_data;
        n_got++;
      end
      tick();
    end
    check_eq("lb_count", 32'(n_got), 32'd4);
    check_eq("lb_byte0", 32'(got[0]), 32'h00);
    check_eq("lb_byte1", 32'(got[1]), 32'hFF);
    check_eq("lb_byte2", 32'(got[2]), 32'h3C);
    check_eq("lb_byte3", 32'(got[3]), 32'h81);
    check_eq("lb_no_errors", 32'((n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0)), 32'd0);
    rx_ready = 1'b0;
    loop_en  = 1'b0;
    repeat (5) tick();

    // Overrun: five frames into a 4-deep FIFO nobody drains
    ov0 = n_ov;
    fe0 = n_fe;
    send_rx(8'h11, 1'b0, 1'b1);
    send_rx(8'h22, 1'b0, 1'b1);
    send_rx(8'h33, 1'b0, 1'b1);
    send_rx(8'h44, 1'b0, 1'b1);
    send_rx(8'h55, 1'b0, 1'b1);
    check_eq("ovr_rx_count", 32'(rx_count), 32'd4);
    check_eq("ovr_pulses", 32'(n_ov - ov0), 32'd1);
    check_eq("ovr_no_frame_err", 32'(n_fe - fe0), 32'd0);
    check_eq("ovr_head", 32'(rx_data), 32'h11);
    pop_one();
    check_eq("ovr_pop2", 32'(rx_data), 32'h22);
    pop_one();
    check_eq("ovr_pop3", 32'(rx_data), 32'h33);
    pop_one();
    check_eq("ovr_pop4", 32'(rx_data), 32'h44);
    pop_one();
    check_eq("ovr_drained", 32'(rx_valid), 32'd0);

    // Stop bit forced low
    fe0 = n_fe;
    send_rx(8'h5A, 1'b0, 1'b0);
    repeat (5) tick();
    check_eq("fe_pulse", 32'(n_fe - fe0), 32'd1);
    check_eq("fe_rx_count", 32'(rx_count), 32'd0);

    // Two-cycle glitch, then a clean frame
    fe0 = n_fe;
    rx_drive = 1'b0;
    repeat (2) tick();
    rx_drive = 1'b1;
    repeat (30) tick();
    check_eq("glitch_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("glitch_no_err", 32'(n_fe - fe0), 32'd0);
    send_rx(8'hC3, 1'b0, 1'b1);
    check_eq("clean_rx_count", 32'(rx_count), 32'd1);
    check_eq("clean_rx_data", 32'(rx_data), 32'hC3);
    pop_one();

`ifdef UART_PARITY_EN
    // 0x07 needs even parity bit 1; sending 0 must be rejected
    pe0 = n_pe;
    send_rx(8'h07, 1'b0, 1'b1);
    check_eq("par_pulse", 32'(n_pe - pe0), 32'd1);
    check_eq("par_not_pushed", 32'(rx_count), 32'd0);
    send_rx(8'h07, 1'b1, 1'b1);
    check_eq("par_good_count", 32'(rx_count), 32'd1);
    check_eq("par_good_data", 32'(rx_data), 32'h07);
    pop_one();
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised, buffered full-duplex UART for the FPGA fabric. It contains its own receive and transmit bit engines and a FIFO in each direction. Both FIFOs present valid/ready handshakes to user logic, so the block replaces direct byte-strobe wiring in top levels such as echo and loopback designs. It also adds configurable data width, error reporting and an optional parity bit.

## Interface

Parameters:

- CLOCK_HZ, 12_000_000, system clock frequency.
- BAUD_RATE, 115200, line rate. DIV = CLOCK_HZ / BAUD_RATE (integer truncation), must be ≥ 4.
- DATA_BITS, 8, bits per character, legal range 5–8.
- FIFO_DEPTH, 16, entries per FIFO, power of two, ≥ 2. AW = $clog2(FIFO_DEPTH).
- PARITY_ODD, 0. Under UART_PARITY_EN: 1 selects odd parity, 0 selects even.

Ports:

- clock  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_pin  in  1  serial input, asynchronous, idle high.
- tx_pin  out  1  serial output, registered, idle high.
- tx_data  in  DATA_BITS  character to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX FIFO can accept a character.
- rx_data  out  DATA_BITS  head of the RX FIFO.
- rx_valid  out  1  RX FIFO is non-empty.
- rx_ready  in  1  consumer accepts rx_data.
- tx_count  out  AW+1  TX FIFO occupancy.
- rx_count  out  AW+1  RX FIFO occupancy.
- overrun  out  1  one-cycle pulse: a received character was dropped because the RX FIFO was full.
- frame_error  out  1  one-cycle pulse: the stop bit was sampled low.
- parity_error  out  1  one-cycle pulse: parity mismatch. Tied 0 without UART_PARITY_EN.

## Operation

- **TX FIFO push:** occurs on tx_valid && tx_ready.
  - tx_ready = !full, and does not depend on a same-cycle pop.
  - Pushes while full are ignored.
- **RX FIFO:** first-word-fall-through.
  - rx_valid = !empty, and rx_data is the head entry.
  - Pop occurs on rx_valid && rx_ready.
  - rx_ready while empty has no effect.
- **FIFO pointers:** AW+1 bits wide, so full and empty are distinguished by the MSB. Pointers wrap modulo 2·FIFO_DEPTH. Count = wr − rd.
- **TX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - In IDLE with the FIFO non-empty: pop the head into the shift register and go to START.
  - Each state holds tx_pin for DIV cycles.
  - Data is sent LSB first.
  - One stop bit (high). A new frame may start on the cycle after STOP completes; there is no extra idle.
- **RX input:** rx_pin passes through a 2-flop synchroniser. The synchroniser flops reset to 1.
- **RX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: detect a high→low transition on the synchronised line.
  - START: sample at DIV/2 cycles. If the sample is high, treat it as a glitch and return to IDLE with no error.
  - DATA and subsequent bits: sampled every DIV cycles after the start mid-point, LSB first.
  - STOP: if the sample is low, pulse frame_error, discard the character, and wait for the line to be high before returning to IDLE.
  - STOP high, parity OK: push the character. If the FIFO is full and no pop occurs in the same cycle, drop the character and pulse overrun. A simultaneous pop makes room and the push succeeds.
- **Errors:** frame_error takes precedence. A character with a parity error is pulsed and discarded, never pushed.
- **Mid-operation reset:** any frame in progress is aborted. tx_pin returns high on the next edge and both FIFOs are emptied.

## Timing

- **Reset values:** tx_pin=1, tx_ready=1, rx_valid=0, rx_data=0, tx_count=0, rx_count=0, overrun=0, frame_error=0, parity_error=0.
- **TX latency:** push accepted at edge N into an idle, empty block → tx_pin falls at edge N+2.
- **Bit length:** each bit is exactly DIV cycles.
- **Frame length:** (1 + DATA_BITS + P + 1)·DIV cycles, where P=1 with parity, else 0.
- **RX latency:** rx_valid rises one cycle after the edge that samples a good stop bit. The pulse outputs fire on that same cycle.
- **Count updates:** counts update on the edge after push or pop. A simultaneous push and pop leaves the count unchanged.

## Configuration

UART_PARITY_EN:

- **Defined:**
  - A parity bit is inserted after the data bits on TX and checked on RX.
  - Parity is even when PARITY_ODD=0 and odd when PARITY_ODD=1.
  - parity_error is live.
- **Undefined:**
  - No PARITY state exists.
  - The frame is start + data + stop.
  - parity_error is tied 0.

## Test plan

All scenarios use CLOCK_HZ=1_000_000, BAUD_RATE=100_000 (DIV=10), DATA_BITS=8, FIFO_DEPTH=4.

- **Reset:** hold reset_n low for 3 cycles → all outputs at their reset values. Inject a frame mid-TX, then reset → tx_pin high on the next edge and tx_count=0.
- **TX frame:** push 0xA5 → tx_pin low from push+2 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high. Total 100 cycles without parity.
- **Loopback burst:** tie tx_pin to rx_pin, push 0x00, 0xFF, 0x3C, 0x81 back-to-back with rx_ready=1 → the same four values pop in order, with no error pulses.
- **Overrun:** rx_ready=0, send 5 frames → rx_count=4, a single overrun pulse on the 5th frame, and rx_data=1st byte.
- **Errors:**
  - Stop bit forced low → frame_error pulse, rx_count unchanged.
  - 2-cycle low glitch on rx_pin → no activity.
- **Parity (macro defined, PARITY_ODD=0):**
  - TX 0x07 → parity bit 1.
  - RX 0x07 with parity bit 0 → parity_error pulse, character not pushed.
